alu_operand_fetch: RTL and testbench

//  Operand-fetch stage directly upstream of the 16-bit ALU (add/xor/passB/sub, zero flag).
//  - Holds the architectural register file.
//  - Reads two source registers and applies write-back bypass.
//  - Selects an immediate for operand B when requested.
//  - Registers {a, b, alu_op} toward the ALU behind a valid/ready handshake, so the ALU sees stable inputs.

---
 rtl/alu_operand_fetch.sv | 151 +++++++++++++++
 tb/tb_alu_operand_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage in front of the 16-bit ALU: register file, write-back bypass,
// immediate select and a one-entry valid/ready output register holding {a, b, alu_op}.
module alu_operand_fetch #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_alu_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use_imm,
    input  logic [WIDTH-1:0]  in_imm,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [1:0]        out_alu_op
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              fire;
    logic [WIDTH-1:0]  regs [NREGS];
    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [1:0]        op_reg;

    // Register file: r0 is hard-wired to zero, every other entry is reset so that
    // no unwritten register can leak X into the ALU.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_live
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        regs[gi] <= '0;
                    end else if (wb_en && (wb_addr == ADDR_W'(gi))) begin
                        regs[gi] <= wb_data;
                    end
                end
            end
        end
    endgenerate

    // Source reads with same-cycle write-back bypass.
    always_comb begin
        src_a = '0;
        if (in_rs1 != '0) begin
            if (wb_en && (wb_addr == in_rs1)) begin
                src_a = wb_data;
            end else begin
                src_a = regs[in_rs1];
            end
        end
    end

    always_comb begin
        src_b = '0;
        if (in_use_imm) begin
            src_b = in_imm;
        end else if (in_rs2 != '0) begin
            if (wb_en && (wb_addr == in_rs2)) begin
                src_b = wb_data;
            end else begin
                src_b = regs[in_rs2];
            end
        end
    end

    assign fire = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (fire) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (fire) begin
                    state_next = FULL;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // in_ready depends only on the state and out_ready, never on in_valid.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        case (state_reg)
            EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    // Operands are frozen at acceptance; later write-backs do not touch a held entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 2'b00;
        end else if (fire) begin
            a_reg  <= src_a;
            b_reg  <= src_b;
            op_reg <= in_alu_op;
        end
    end

    assign out_a      = a_reg;
    assign out_b      = b_reg;
    assign out_alu_op = op_reg;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: directed scenarios plus randomized traffic,
// expectations from a register-array model of the architectural rules.
module tb_alu_operand_fetch;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_alu_op;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [1:0]  out_alu_op;

    int          total;
    int          bad;
    exp_t        q[$];
    logic [15:0] mregs [8];
    logic        model_full;

    alu_operand_fetch #(.WIDTH(16), .NREGS(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_op  (in_alu_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_alu_op (out_alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input logic [2:0] rs, input logic we,
                                       input logic [2:0] wa, input logic [15:0] wd);
        if (rs == 3'd0) return 16'h0000;
        if (we && wa == rs) return wd;
        return mregs[rs];
    endfunction

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_alu_op  = 2'b00;
        in_rs1     = 3'd0;
        in_rs2     = 3'd0;
        in_use_imm = 1'b0;
        in_imm     = 16'h0000;
        wb_en      = 1'b0;
        wb_addr    = 3'd0;
        wb_data    = 16'h0000;
        out_ready  = 1'b1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        model_full = 1'b0;
        q.delete();
    endtask

    // One clock of stimulus: drive at negedge+2, predict, commit model after posedge.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [2:0] r1,
                         input logic [2:0] r2, input logic ui, input logic [15:0] imm,
                         input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic ordy);
        exp_t e;
        logic exp_rdy;
        logic f;
        @(negedge clk);
        #2;
        in_valid   = v;
        in_alu_op  = op;
        in_rs1     = r1;
        in_rs2     = r2;
        in_use_imm = ui;
        in_imm     = imm;
        wb_en      = we;
        wb_addr    = wa;
        wb_data    = wd;
        out_ready  = ordy;
        exp_rdy    = !model_full || ordy;
        #1;
        total++;
        if (in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, exp_rdy);
        end
        f    = v && exp_rdy;
        e.a  = rd(r1, we, wa, wd);
        e.b  = ui ? imm : rd(r2, we, wa, wd);
        e.op = op;
        @(posedge clk);
        #1;
        if (f) q.push_back(e);
        model_full = f ? 1'b1 : (ordy ? 1'b0 : model_full);
        if (we && wa != 3'd0) mregs[wa] = wd;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (out_valid !== 1'b0 || out_a !== 16'h0 || out_b !== 16'h0 ||
            out_alu_op !== 2'b00 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s got v=%b a=%h b=%h op=%b rdy=%b want v=0 a=0000 b=0000 op=00 rdy=1",
                     tag, out_valid, out_a, out_b, out_alu_op, in_ready);
        end
    endtask

    // Monitor: compares the held entry every cycle (stability) and pops on drain.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) continue;
            total++;
            if (out_valid !== (q.size() != 0)) begin
                bad++;
                $display("FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, q.size() != 0);
            end else if (out_valid) begin
                total++;
                if (out_a !== q[0].a || out_b !== q[0].b || out_alu_op !== q[0].op) begin
                    bad++;
                    $display("FAIL operands t=%0t got a=%h b=%h op=%b want a=%h b=%h op=%b",
                             $time, out_a, out_b, out_alu_op, q[0].a, q[0].b, q[0].op);
                end
                if (out_ready) begin
                    $display("txn t=%0t a=%h b=%h op=%b", $time, out_a, out_b, out_alu_op);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog timeout got=running want=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        #1;
        rst = 1'b0;

        // T1: write r1, r2 then xor them
        cycle(0, 2'b00, 0, 0, 0, 16'h0, 1, 3'd1, 16'h0005, 1);
        cycle(0, 2'b00, 0, 0, 0, 16'h0, 1, 3'd2, 16'h0003, 1);
        cycle(1, 2'b01, 1, 2, 0, 16'h0, 0, 3'd0, 16'h0, 1);
        cycle(0, 2'b00, 0, 0, 0, 16'h0, 0, 3'd0, 16'h0, 1);
        // T2: same-cycle bypass plus immediate
        cycle(1, 2'b00, 3, 0, 1, 16'h4321, 1, 3'd3, 16'h1234, 1);
        // T3: writes to r0 are dropped
        cycle(0, 2'b00, 0, 0, 0, 16'h0, 1, 3'd0, 16'hFFFF, 1);
        cycle(1, 2'b11, 0, 0, 0, 16'h0, 0, 3'd0, 16'h0, 1);
        cycle(1, 2'b11, 0, 0, 0, 16'h0, 1, 3'd0, 16'hFFFF, 1);
        // T4: three stalled cycles, then back-to-back drain
        cycle(1, 2'b00, 1, 2, 0, 16'h0, 0, 3'd0, 16'h0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 2'b10, 3, 1, 0, 16'h0, 0, 3'd0, 16'h0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 2'(i), 3'(i + 1), 3'(i + 2), 0, 16'h0, 0, 3'd0, 16'h0, 1);
        // T5: write-back during stall leaves captured operand untouched
        cycle(0, 2'b00, 0, 0, 0, 16'h0, 1, 3'd4, 16'h0008, 1);
        cycle(1, 2'b10, 4, 0, 1, 16'h0055, 0, 3'd0, 16'h0, 0);
        cycle(0, 2'b00, 0, 0, 0, 16'h0, 1, 3'd4, 16'h00FF, 0);
        cycle(0, 2'b00, 0, 0, 0, 16'h0, 0, 3'd0, 16'h0, 1);
        cycle(1, 2'b00, 4, 4, 0, 16'h0, 0, 3'd0, 16'h0, 1);
        // T6: asynchronous reset with a held entry
        for (int i = 1; i < 8; i++) cycle(0, 2'b00, 0, 0, 0, 16'h0, 1, 3'(i), 16'hA000 + 16'(i), 1);
        cycle(1, 2'b01, 5, 6, 0, 16'h0, 0, 3'd0, 16'h0, 0);
        #1;
        rst = 1'b1;
        idle_inputs();
        #1;
        check_reset_outputs("async_reset");
        model_clear();
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i < 8; i++) cycle(1, 2'b00, 3'(i), 3'(8 - i), 0, 16'h0, 0, 3'd0, 16'h0, 1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 16'($urandom), $urandom_range(0, 1) == 1, 3'($urandom),
                  16'($urandom), $urandom_range(0, 9) < 7);
        end

        repeat (3) cycle(0, 2'b00, 0, 0, 0, 16'h0, 0, 3'd0, 16'h0, 1);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
